fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_if.sv | 23 ++
 rtl/fetch_buffer.sv | 36 +++
 rtl/fetch.sv | 130 +++++++++++++
 tb/tb_fetch.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state encoding for the fetch stage
package fetch_pkg;

  localparam logic [31:0] NOP              = 32'h00000013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h00000000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_KILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction memory request/response bus
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - one-entry skid buffer for a word accepted while decode is stalled
module fetch_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  input  logic [31:0] i_pc,
  output logic [31:0] o_data,
  output logic [31:0] o_pc,
  output logic        o_full
);

  logic [31:0] r_data;
  logic [31:0] r_pc;
  logic        r_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
      r_pc   <= '0;
      r_full <= 1'b0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_pc   <= i_pc;
      r_full <= 1'b1;
    end
  end

  assign o_data = r_data;
  assign o_pc   = r_pc;
  assign o_full = r_full;

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage: PC sequencing, memory handshake, redirect and stall handling
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hlt,
  input  logic        redirect,
  input  logic [31:0] target,
  fetch_if.master     imem,
  output logic [31:0] instruction,
  output logic [31:0] outpc
);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_stale, w_stale_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_outpc, w_outpc_nxt;
  logic [31:0] w_target;
  logic        w_buf_load, w_buf_clear, w_buf_full;
  logic [31:0] w_buf_data, w_buf_pc;

  fetch_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_data  (imem.imem_data),
    .i_pc    (r_pc),
    .o_data  (w_buf_data),
    .o_pc    (w_buf_pc),
    .o_full  (w_buf_full)
  );

  // KILL keeps presenting the abandoned address until the memory acks it.
  assign imem.imem_req  = rst && (r_state != ST_HOLD);
  assign imem.imem_addr = (r_state == ST_KILL) ? r_stale : r_pc;
  assign w_target       = target & 32'hFFFF_FFFC;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_stale_nxt = r_stale;
    w_instr_nxt = r_instr;
    w_outpc_nxt = r_outpc;
    w_buf_load  = 1'b0;
    w_buf_clear = 1'b0;
    case (r_state)
      ST_REQ: begin
        if (redirect) begin
          w_pc_nxt    = w_target;
          w_buf_clear = 1'b1;
          if (!imem.imem_ack) begin
            w_state_nxt = ST_KILL;
            w_stale_nxt = r_pc;
          end
          if (!hlt) begin
            w_instr_nxt = NOP;
            w_outpc_nxt = r_pc;
          end
        end else if (imem.imem_ack) begin
          w_pc_nxt = r_pc + 32'd4;
          if (hlt) begin
            w_buf_load  = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_instr_nxt = imem.imem_data;
            w_outpc_nxt = r_pc;
          end
        end else if (!hlt) begin
          w_instr_nxt = NOP;
          w_outpc_nxt = r_pc;
        end
      end
      ST_KILL: begin
        if (redirect) begin
          w_pc_nxt    = w_target;
          w_buf_clear = 1'b1;
        end
        if (imem.imem_ack) w_state_nxt = ST_REQ;
        if (!hlt) begin
          w_instr_nxt = NOP;
          w_outpc_nxt = r_pc;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          w_pc_nxt    = w_target;
          w_buf_clear = 1'b1;
          w_state_nxt = ST_REQ;
          if (!hlt) begin
            w_instr_nxt = NOP;
            w_outpc_nxt = r_pc;
          end
        end else if (!w_buf_full) begin
          w_state_nxt = ST_REQ;
        end else if (!hlt) begin
          w_instr_nxt = w_buf_data;
          w_outpc_nxt = w_buf_pc;
          w_buf_clear = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      default: w_state_nxt = ST_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_REQ;
      r_pc    <= RESET_PC;
      r_stale <= RESET_PC;
      r_instr <= NOP;
      r_outpc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_stale <= w_stale_nxt;
      r_instr <= w_instr_nxt;
      r_outpc <= w_outpc_nxt;
    end
  end

  assign instruction = r_instr;
  assign outpc       = r_outpc;

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - directed vector bench for the fetch stage
module tb_fetch;

  localparam logic [31:0] EXP_NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hlt = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] instruction;
  logic [31:0] outpc;

  int n_checks = 0;
  int n_errors = 0;

  fetch_if bus ();

  fetch dut (
    .clk         (clk),
    .rst         (rst),
    .hlt         (hlt),
    .redirect    (redirect),
    .target      (target),
    .imem        (bus),
    .instruction (instruction),
    .outpc       (outpc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hC0DE0000 ^ a;
  endfunction

  assign bus.imem_data = word_at(bus.imem_addr);

  typedef struct {
    logic        hlt;
    logic        redirect;
    logic [31:0] target;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic        chk_pc;
    logic [31:0] exp_outpc;
    string       name;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic h, input logic r, input logic [31:0] t, input logic a,
                     input logic er, input logic [31:0] ea, input logic [31:0] ei,
                     input logic cp, input logic [31:0] eo, input string nm);
    vec_t v;
    v.hlt = h; v.redirect = r; v.target = t; v.ack = a;
    v.exp_req = er; v.exp_addr = ea; v.exp_instr = ei;
    v.chk_pc = cp; v.exp_outpc = eo; v.name = nm;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.imem_ack = 1'b0;

    add(0,0,0,1, 1,32'h0,      word_at(32'h0),       1,32'h0,       "zw0");
    add(0,0,0,1, 1,32'h4,      word_at(32'h4),       1,32'h4,       "zw4");
    add(0,0,0,1, 1,32'h8,      word_at(32'h8),       1,32'h8,       "zw8");
    add(0,0,0,0, 1,32'hC,      EXP_NOP,              1,32'hC,       "wait1");
    add(0,0,0,0, 1,32'hC,      EXP_NOP,              1,32'hC,       "wait2");
    add(0,0,0,1, 1,32'hC,      word_at(32'hC),       1,32'hC,       "waitack");
    add(0,1,32'h100,0, 1,32'h10, EXP_NOP,            0,32'h0,       "redir_pend");
    add(0,0,0,0, 1,32'h10,     EXP_NOP,              0,32'h0,       "kill_hold");
    add(0,0,0,1, 1,32'h10,     EXP_NOP,              0,32'h0,       "kill_drop");
    add(0,0,0,1, 1,32'h100,    word_at(32'h100),     1,32'h100,     "after_kill");
    add(1,0,0,1, 1,32'h104,    word_at(32'h100),     1,32'h100,     "hlt_ack");
    add(1,0,0,0, 0,32'h0,      word_at(32'h100),     1,32'h100,     "hold_frz");
    add(0,0,0,0, 0,32'h0,      word_at(32'h104),     1,32'h104,     "hold_drain");
    add(0,0,0,1, 1,32'h108,    word_at(32'h108),     1,32'h108,     "post_hold");
    add(0,1,32'h203,1, 1,32'h10C, EXP_NOP,           0,32'h0,       "redir_ack");
    add(0,0,0,1, 1,32'h200,    word_at(32'h200),     1,32'h200,     "aligned_tgt");
    add(0,1,32'hFFFFFFFC,1, 1,32'h204, EXP_NOP,      0,32'h0,       "redir_top");
    add(0,0,0,1, 1,32'hFFFFFFFC, word_at(32'hFFFFFFFC), 1,32'hFFFFFFFC, "top_word");
    add(0,0,0,1, 1,32'h0,      word_at(32'h0),       1,32'h0,       "wrap");
    add(1,0,0,1, 1,32'h4,      word_at(32'h0),       1,32'h0,       "hlt_ack2");
    add(0,1,32'h40,0, 0,32'h0, EXP_NOP,              0,32'h0,       "redir_hold");
    add(0,0,0,1, 1,32'h40,     word_at(32'h40),      1,32'h40,      "after_rh");
    add(0,1,32'h80,0, 1,32'h44, EXP_NOP,             0,32'h0,       "kill_a");
    add(0,1,32'h90,0, 1,32'h44, EXP_NOP,             0,32'h0,       "kill_b");
    add(0,0,0,1, 1,32'h44,     EXP_NOP,              0,32'h0,       "kill_end");
    add(0,0,0,1, 1,32'h90,     word_at(32'h90),      1,32'h90,      "after_kill2");

    tick();
    tick();
    check("rst_req",   {31'd0, bus.imem_req}, 32'd0);
    check("rst_instr", instruction, EXP_NOP);
    check("rst_outpc", outpc, 32'h0);

    rst = 1'b1;
    #1;
    check("rel_req",  {31'd0, bus.imem_req}, 32'd1);
    check("rel_addr", bus.imem_addr, 32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      hlt = vq[i].hlt;
      redirect = vq[i].redirect;
      target = vq[i].target;
      bus.imem_ack = vq[i].ack;
      #1;
      check({vq[i].name, "_req"}, {31'd0, bus.imem_req}, {31'd0, vq[i].exp_req});
      if (vq[i].exp_req) check({vq[i].name, "_addr"}, bus.imem_addr, vq[i].exp_addr);
      tick();
      check({vq[i].name, "_instr"}, instruction, vq[i].exp_instr);
      if (vq[i].chk_pc) check({vq[i].name, "_outpc"}, outpc, vq[i].exp_outpc);
    end

    // reset asserted while a killed request is outstanding
    hlt = 1'b0; redirect = 1'b1; target = 32'h300; bus.imem_ack = 1'b0;
    tick();
    redirect = 1'b0;
    check("kill_addr", bus.imem_addr, 32'h94);
    rst = 1'b0;
    #1;
    check("krst_req",   {31'd0, bus.imem_req}, 32'd0);
    check("krst_instr", instruction, EXP_NOP);
    check("krst_outpc", outpc, 32'h0);
    tick();
    tick();
    check("krst_req2", {31'd0, bus.imem_req}, 32'd0);
    rst = 1'b1;
    #1;
    check("krel_req",   {31'd0, bus.imem_req}, 32'd1);
    check("krel_addr",  bus.imem_addr, 32'h0);
    check("krel_instr", instruction, EXP_NOP);
    bus.imem_ack = 1'b1;
    tick();
    check("krel_word",  instruction, word_at(32'h0));
    check("krel_outpc", outpc, 32'h0);
    check("krel_next",  bus.imem_addr, 32'h4);
    bus.imem_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
